// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, bit timing and one-hot controller states for the UART TX queue.
package uart_pkg;
  localparam int D_BIT = 7;
  localparam int TICKS_PER_BIT = 16;
  localparam int TIMEOUT_TICKS_DEF = 192;
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_LOAD = 4'b0010,
    S_ARM  = 4'b0100,
    S_WAIT = 4'b1000
  } state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: register-based FIFO with level, full/empty and a dropped-write pulse.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] level_q;
  logic ovf_q, push, pop;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign rd_data = mem_q[rp_q];
  assign level = level_q;
  assign overflow = ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) mem_q[wp_q] <= wr_data;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_q <= wr_en && full;
    end
  end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: queues host bytes and hands them one at a time to the UART transmitter.
// Optional frame timeout with TXQ_TIMEOUT_EN (adds TIMEOUT_TICKS and timeout_err).
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
`ifdef TXQ_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [D_BIT:0]         wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   tick_in,
  input  logic                   tx_done_tick,
  output logic [D_BIT:0]         dato_in,
  output logic                   tx_start,
  output logic                   busy
`ifdef TXQ_TIMEOUT_EN
  , output logic                 timeout_err
`endif
);
  state_e state_q, state_d;
  logic [D_BIT:0] dato_q, dato_d, head;
  logic start_q, start_d, pop, empty, q1_q, q2_q, done_edge, tmo_hit;
  uart_sync_fifo #(.DEPTH(DEPTH), .W(D_BIT + 1)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop),
    .rd_data(head), .full(full), .empty(empty), .overflow(overflow), .level(level)
  );
  assign done_edge = q1_q && !q2_q;
`ifdef TXQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] cnt_q;
  logic terr_q;
  assign tmo_hit = state_q == S_WAIT && tick_in && !done_edge && cnt_q == TW'(TIMEOUT_TICKS - 1);
  assign timeout_err = terr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_WAIT) ? cnt_q + TW'(tick_in) : '0;
      terr_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dato_q <= '0;
      start_q <= 1'b0;
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dato_q <= dato_d;
      start_q <= start_d;
      q1_q <= tx_done_tick;
      q2_q <= q1_q;
    end
  end
  // dato_in only changes on a pop in IDLE, so it is frozen for the whole frame
  always_comb begin
    state_d = state_q;
    dato_d = dato_q;
    start_d = start_q;
    pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop = !empty;
        dato_d = empty ? dato_q : head;
        state_d = empty ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        start_d = 1'b1;
        state_d = S_ARM;
      end
      S_ARM: begin
        start_d = !tick_in;
        state_d = tick_in ? S_WAIT : S_ARM;
      end
      S_WAIT: state_d = (done_edge || tmo_hit) ? S_IDLE : S_WAIT;
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
      end
    endcase
  end
  assign dato_in = dato_q;
  assign tx_start = start_q;
  assign busy = state_q inside {S_LOAD, S_ARM, S_WAIT};
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: table-driven cycle checks plus transmitter-model frame sequences.
module tb_uart_tx_queue;
  logic clk = 0, rst_n = 0, wr_en = 0;
  logic [7:0] wr_data = 0;
  logic tick_tab = 0, tick_gen = 0, done_tab = 0, done_mdl = 0, gen_en = 0;
  logic full, overflow, tx_start, busy;
  logic [4:0] level;
  logic [7:0] dato_in;
`ifdef TXQ_TIMEOUT_EN
  logic timeout_err;
`endif
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  uart_tx_queue #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full), .level(level),
    .overflow(overflow), .tick_in(tick_tab | tick_gen), .tx_done_tick(done_tab | done_mdl),
    .dato_in(dato_in), .tx_start(tx_start), .busy(busy)
`ifdef TXQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );
  typedef struct {
    logic w; logic [7:0] d; logic t; logic dn;
    logic [4:0] lvl; logic fl; logic ov; logic st; logic bz; logic [7:0] dat;
  } vec_t;
  vec_t tab[$];
  function automatic vec_t mk(input logic w, input logic [7:0] d, input logic t, input logic dn,
                              input logic [4:0] lvl, input logic fl, input logic ov, input logic st,
                              input logic bz, input logic [7:0] dat);
    vec_t v;
    v.w = w; v.d = d; v.t = t; v.dn = dn; v.lvl = lvl; v.fl = fl; v.ov = ov; v.st = st; v.bz = bz; v.dat = dat;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // baud tick every 8 clk while enabled
  int div = 0;
  initial forever begin
    @(negedge clk);
    tick_gen = gen_en && div == 7;
    div = gen_en ? (div + 1) % 8 : 0;
  end
  // transmitter model: latch on a sampled tick with tx_start, done 160 ticks later
  logic [7:0] rx[$];
  logic [7:0] cap;
  int mst = 0, tcnt = 0, lat = 0, max_lat = 0, n_lat = 0;
  bit meas = 0, changed = 0, sp = 0;
  initial forever begin
    @(posedge clk);
    done_mdl <= 1'b0;
    if (meas) begin
      lat++;
      if (tx_start && !sp) begin
        meas = 0;
        n_lat++;
        if (lat - 1 > max_lat) max_lat = lat - 1;
      end
    end
    sp = tx_start;
    if (mst == 0 && tick_gen && tx_start) begin
      cap = dato_in;
      rx.push_back(dato_in);
      tcnt = 0;
      mst = 1;
    end else if (mst == 1) begin
      if (dato_in !== cap) changed = 1;
      if (tick_gen) begin
        tcnt++;
        if (tcnt == 160) begin
          done_mdl <= 1'b1;
          mst = 0;
          if (level != 0) begin
            meas = 1;
            lat = 0;
          end
        end
      end
    end
  end
  task automatic wait_frames(input int n);
    int k = 0;
    while (!(rx.size() == n && !busy && level == 0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("frame_wait", 32'(k < 20000), 1);
  endtask
`ifdef TXQ_TIMEOUT_EN
  task automatic wait_start();
    int k = 0;
    while (!tx_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("arm_wait", 32'(k < 100), 1);
  endtask
  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_tab = 1;
      @(negedge clk);
      tick_tab = 0;
      if (timeout_err) chk("early_timeout", 32'(timeout_err), 0);
      @(negedge clk);
    end
  endtask
`endif
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end
  initial begin
    tab.push_back(mk(1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 8'h00));
    tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'hA5));
    tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 8'hA5));
    tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 8'hA5));
    tab.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 8'hA5));
    for (int i = 0; i < 16; i++)
      tab.push_back(mk(1, 8'h10 + 8'(i), 0, 0, 5'(i + 1), i == 15, 0, 0, 1, 8'hA5));
    tab.push_back(mk(1, 8'hEE, 0, 0, 16, 1, 1, 0, 1, 8'hA5));
    tab.push_back(mk(0, 8'h00, 0, 0, 16, 1, 0, 0, 1, 8'hA5));
    tab.push_back(mk(0, 8'h00, 0, 1, 16, 1, 0, 0, 1, 8'hA5));
    tab.push_back(mk(0, 8'h00, 0, 1, 16, 1, 0, 0, 0, 8'hA5));
    tab.push_back(mk(1, 8'hEE, 0, 1, 15, 0, 1, 0, 1, 8'h10));
    tab.push_back(mk(0, 8'h00, 0, 0, 15, 0, 0, 1, 1, 8'h10));
    tab.push_back(mk(0, 8'h00, 1, 0, 15, 0, 0, 0, 1, 8'h10));
    repeat (2) @(negedge clk);
    chk("reset_state", {level, full, overflow, tx_start, busy, dato_in}, 0);
    rst_n = 1;
    foreach (tab[i]) begin
      wr_en = tab[i].w; wr_data = tab[i].d; tick_tab = tab[i].t; done_tab = tab[i].dn;
      @(negedge clk);
      chk($sformatf("row%0d", i), {level, full, overflow, tx_start, busy, dato_in},
          {tab[i].lvl, tab[i].fl, tab[i].ov, tab[i].st, tab[i].bz, tab[i].dat});
    end
    wr_en = 0; tick_tab = 0; done_tab = 0;
    #2 rst_n = 0;
    #1 chk("async_reset", {level, full, overflow, tx_start, busy, dato_in}, 0);
    @(negedge clk);
    rst_n = 1;
    done_tab = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("late_done%0d", i), {level, tx_start, busy}, 0);
    end
    done_tab = 0;
    gen_en = 1;
    wr_en = 1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 0;
    wait_frames(1);
    chk("frame_a5", rx[0], 8'hA5);
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1; wr_data = 8'(i);
      @(negedge clk);
    end
    wr_en = 0;
    wait_frames(4);
    chk("frame_1", rx[1], 8'h01);
    chk("frame_2", rx[2], 8'h02);
    chk("frame_3", rx[3], 8'h03);
    chk("dato_stable", 32'(changed), 0);
    chk("restart_count", n_lat, 2);
    chk("restart_latency", 32'(max_lat <= 4), 1);
`ifdef TXQ_TIMEOUT_EN
    gen_en = 0;
    repeat (4) @(negedge clk);
    wr_en = 1; wr_data = 8'hB1;
    @(negedge clk);
    wr_data = 8'hB2;
    @(negedge clk);
    wr_en = 0;
    wait_start();
    chk("tmo_first", dato_in, 8'hB1);
    pulse_ticks(1);
    pulse_ticks(191);
    chk("tmo_busy", 32'(busy), 1);
    tick_tab = 1;
    @(negedge clk);
    tick_tab = 0;
    chk("tmo_pulse", 32'(timeout_err), 1);
    @(negedge clk);
    chk("tmo_single", 32'(timeout_err), 0);
    wait_start();
    chk("tmo_next", dato_in, 8'hB2);
    pulse_ticks(1);
    pulse_ticks(191);
    done_tab = 1;
    @(negedge clk);
    tick_tab = 1;
    @(negedge clk);
    tick_tab = 0;
    done_tab = 0;
    chk("tie_no_err", {31'd0, timeout_err}, 0);
    chk("tie_idle", 32'(busy), 0);
    @(negedge clk);
    chk("tie_no_err2", 32'(timeout_err), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Upstream feeder for the UART transmitter (8 data bits, 16 ticks per bit).
- Buffers bytes written by the host logic in a FIFO, presents one byte at a time on the transmitter's data input, pulses its start request, and waits for its done indication before issuing the next byte.
- Runs on the system clock; receives the same baud tick strobe that clocks the transmitter.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
- TIMEOUT_TICKS, 192, baud ticks allowed per frame before timeout (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  host write strobe
- wr_data  in  8  host byte
- full  out  1  FIFO full
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  one-cycle pulse when a write is dropped
- tick_in  in  1  baud tick; one-clk-wide strobe in the clk domain, same signal that clocks the transmitter
- tx_done_tick  in  1  done flag from the transmitter
- dato_in  out  8  byte to the transmitter
- tx_start  out  1  start request to the transmitter
- busy  out  1  a frame is in progress
- timeout_err  out  1  one-cycle pulse; present only with TXQ_TIMEOUT_EN

Behaviour:
- One clock; reset is asynchronous and active-low. All flops clear on rst_n low.
- Reset values: FIFO empty, level=0, full=0, overflow=0, dato_in=8'h00, tx_start=0, busy=0, timeout_err=0, state=IDLE, done synchronizer=0.
- Write: wr_en && !full stores wr_data at the next edge.
- wr_en && full: byte dropped, overflow=1 for one cycle.
- full is evaluated before the edge, so a write while full is dropped even if a pop occurs in the same cycle.
- Simultaneous write and pop when not full: both take effect; level is unchanged.
- No fall-through: a byte written into an empty FIFO is poppable one cycle later. Minimum wr_en to tx_start latency is 2 clk.
- State encoding is one-hot 4-bit: IDLE=0001, LOAD=0010, ARM=0100, WAIT_DONE=1000. An illegal state returns to IDLE with tx_start=0.
- IDLE: if !empty, pop the head into dato_in and go to LOAD. Otherwise stay.
- LOAD: set tx_start=1 and go to ARM. dato_in is stable for at least one cycle before tx_start rises.
- ARM: hold tx_start=1. On a clk edge sampling tick_in=1, the transmitter has already sampled the request, so clear tx_start and go to WAIT_DONE.
- WAIT_DONE: hold dato_in stable. The transmitter latches data while idle, so dato_in must not change until the frame ends. Wait for a rising edge of tx_done_tick, then go to IDLE.
- tx_done_tick passes through a 2-flop synchronizer plus an edge detect (q1 && !q2). Edges seen in IDLE, LOAD or ARM are ignored.
- busy=1 in LOAD, ARM and WAIT_DONE.
- Back-to-back: IDLE pops in the cycle after the done edge. tick_in period is at least 8 clk, so tx_start rises before the transmitter's next idle tick.
- Reset mid-frame: the controller returns to IDLE and the queue is flushed. The transmitter is not reset and finishes its frame on the line. The resulting done edge arrives in IDLE and is ignored.
- level saturates at DEPTH, and full = (level==DEPTH). Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: TXQ_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT_DONE and increments on each tick_in.
  - If it reaches TIMEOUT_TICKS with no done edge: timeout_err pulses 1 cycle, the byte is discarded, the state goes to IDLE and the next byte proceeds.
  - A done edge and the terminal count in the same cycle count as done; no error.
- Without the macro: no counter and no timeout_err port; WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_pkg: D_BIT=7 (data width D_BIT+1), TICKS_PER_BIT=16, the one-hot state localparams above, default TIMEOUT_TICKS=192 (10 bits × 16 ticks plus margin).
- One sub-module, uart_sync_fifo: parameterized DEPTH/width register-based FIFO with full/empty/level. Controller FSM, synchronizer and optional timeout counter stay in uart_tx_queue.

Test Plan:
1. Reset mid-WAIT_DONE with 3 bytes queued → all outputs at reset values, level=0; later done edge ignored, tx_start stays 0.
2. Write 8'hA5 into an empty FIFO; model transmitter returns done 160 ticks later → dato_in=8'hA5, tx_start high 2 clk after write until the first sampled tick, busy drops after the done edge, level 1→0.
3. Write 8'h01,8'h02,8'h03 back-to-back → three frames in order. dato_in never changes during WAIT_DONE. Each tx_start rises within 4 clk of the previous done edge.
4. With DEPTH=16: write 17 bytes with no transmitter progress → full=1 after 16 writes, 17th dropped with a single-cycle overflow, level=16.
5. When full, wr_en with a simultaneous pop → write dropped, overflow=1, level=15.
6. (TXQ_TIMEOUT_EN) Transmitter held silent → timeout_err pulses exactly at tick 192 of WAIT_DONE, next byte armed; done at tick 192 gives no error.
